// File: rtl/p_decoder_pkg.sv
// Shared constants for the priority decoder pipeline: index width helper and
// the default one-hot seed.
package p_decoder_pkg;

   localparam int unsigned DEF_BW = 8;

   function automatic int unsigned idx_w(input int unsigned bw);
      return (bw < 2) ? 1 : $clog2(bw);
   endfunction

   localparam int unsigned        DEF_IW         = idx_w(DEF_BW);
   localparam logic [DEF_BW-1:0]  DEF_ONEHOT_LSB = DEF_BW'(1);

endpackage

// File: rtl/p_decoder_comb.sv
// Combinational index-to-one-hot decoder; exact inverse of the priority encoder.
// The zero flag outranks the index, and an out-of-range index flags an error.
module p_decoder_comb
   import p_decoder_pkg::*;
#(
   parameter  int unsigned BW = DEF_BW,
   localparam int unsigned IW = idx_w(BW)
) (
   input  logic [IW-1:0] idx_i,
   input  logic          zero_i,
   output logic [BW-1:0] onehot_o,
   output logic          err_o
);

   localparam logic [BW-1:0] ONEHOT_LSB = BW'(1);

   logic in_range;
   assign in_range = 32'(idx_i) < BW;

   always_comb begin
      onehot_o = '0;
      err_o    = 1'b0;
      if (!zero_i) begin
         if (in_range) onehot_o = ONEHOT_LSB << idx_i;
         else          err_o    = 1'b1;
      end
   end

endmodule

// File: rtl/p_decoder_pipe.sv
// Two-stage valid/ready pipeline around p_decoder_comb. S1 holds the raw index,
// S2 holds the decoded result and drives the outputs directly.
module p_decoder_pipe
   import p_decoder_pkg::*;
#(
   parameter  int unsigned BW = DEF_BW,
   localparam int unsigned IW = idx_w(BW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_idx,
   input  logic          in_zero,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_onehot,
   output logic          out_err
);

   logic          v1_q, v1_d, v2_q, v2_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          zero_q, zero_d;
   logic [BW-1:0] oh_q, oh_d;
   logic          err_q, err_d;
   logic [BW-1:0] dec_oh;
   logic          dec_err;
   logic          ready1, ready2;

   // An empty stage always accepts, so bubbles collapse under backpressure.
   assign ready2   = !v2_q | out_ready;
   assign ready1   = !v1_q | ready2;
   assign in_ready = ready1;

   p_decoder_comb #(.BW(BW)) u_dec (
      .idx_i    (idx_q),
      .zero_i   (zero_q),
      .onehot_o (dec_oh),
      .err_o    (dec_err)
   );

   always_comb begin
      v1_d   = v1_q;
      idx_d  = idx_q;
      zero_d = zero_q;
      v2_d   = v2_q;
      oh_d   = oh_q;
      err_d  = err_q;
      if (ready2) begin
         v2_d = v1_q;
         if (v1_q) begin
            oh_d  = dec_oh;
            err_d = dec_err;
         end
      end
      if (ready1) begin
         v1_d = in_valid;
         if (in_valid) begin
            idx_d  = in_idx;
            zero_d = in_zero;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         idx_q  <= '0;
         zero_q <= 1'b0;
         v2_q   <= 1'b0;
         oh_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         idx_q  <= idx_d;
         zero_q <= zero_d;
         v2_q   <= v2_d;
         oh_q   <= oh_d;
         err_q  <= err_d;
      end
   end

   assign out_valid  = v2_q;
   assign out_onehot = oh_q;
   assign out_err    = err_q;

endmodule

// File: doc/p_decoder_pipe.md
Name: p_decoder_pipe

Overview:
- Inverse of the priority encoder: converts a binary bit index (plus zero flag) back into a BW-bit one-hot vector.
- Used where a leading-one position from the encode side must be re-expanded, e.g. anti-log reconstruction in the approximate multiply path.
- Two-stage registered pipeline with valid/ready handshake on both sides; full throughput; backpressure-safe.

Parameters:
- BW, 8, width of the one-hot output; index width IW = $clog2(BW); BW >= 2, need not be a power of two.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  upstream offers a beat
- in_ready  output  1  block accepts the beat this cycle
- in_idx  input  IW  bit index to decode
- in_zero  input  1  encoded source was all-zero; output must be all-zero
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the beat
- out_onehot  output  BW  decoded vector
- out_err  output  1  in_idx >= BW and in_zero = 0 (illegal index)

Behaviour:
- Reset: on a clk edge with rst_n = 0, all valid bits, out_onehot, out_err, and stage registers clear to 0. in_ready = 1 in the first cycle after reset. Reset asserted mid-stream drops all in-flight beats; no partial output.
- Handshake: transfer on in_valid & in_ready (input) and out_valid & out_ready (output). out_valid, out_onehot, and out_err hold stable while out_valid & !out_ready. A registered input beat never drops or duplicates.
- Stage 1 (S1) registers in_idx, in_zero, and v1.
- Stage 2 (S2) registers the decoded vector, the error flag, and v2. These drive the out_* ports directly.
- Per-stage advance rule:
  - ready2 = !v2 | out_ready
  - ready1 = !v1 | ready2
  - in_ready = ready1 (combinational, no input-to-output comb path through data)
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Bubble collapse: an empty stage accepts even when downstream is stalled.
- Decode rule, in priority order:
  - in_zero = 1 → onehot = 0, err = 0, regardless of idx
  - idx < BW → onehot = 1 << idx, err = 0
  - otherwise → onehot = 0, err = 1
- Exactly one bit is set whenever err = 0 and in_zero = 0.
- Simultaneous events:
  - S2 drains and S1 refills in the same cycle → no bubble.
  - Input accepted while S1 moves to S2 → no bubble.
  - out_ready low with both stages full → in_ready = 0 in the same cycle.
- No FSM beyond the two valid bits. States by {v1, v2}:
  - 00 empty
  - 10 or 01 half
  - 11 full
  - Transitions follow directly from the advance rule.

Decomposition:
- Shared package holds:
  - the IW = $clog2(BW) helper constant
  - a localparam for the one-hot LSB (BW'(1))
- One natural sub-module: p_decoder_comb, a purely combinational idx/zero to {onehot, err} decoder instantiated between S1 and S2. It gives the exact inverse of the encoder and is independently testable.
- Pipeline registers and handshake stay in p_decoder_pipe.

Test Plan:
- Sweep, BW=8: idx 0..7, in_zero=0, out_ready=1, one beat per cycle → outputs 8'h01, 8'h02, …, 8'h80 on consecutive cycles starting 2 cycles after the first input, err=0.
- Zero flag: idx=5, in_zero=1 → onehot=8'h00, err=0.
- Illegal index, BW=6 (IW=3): idx=6, then idx=7 → onehot=6'h00, err=1 both beats; idx=5 → 6'h20, err=0.
- Backpressure:
  - Send idx 1, 2, 3 back-to-back with out_ready=0.
  - in_ready drops after the second beat; out_onehot holds 8'h02 stable.
  - Raise out_ready → 8'h02, 8'h04, 8'h08 in order, no loss or duplicate.
- Reset mid-operation: both stages full, rst_n=0 for one cycle → next cycle out_valid=0, out_onehot=0, in_ready=1. A beat sent afterwards emerges after 2 cycles.
- Random round trip: random one-hot → encoder → p_decoder_pipe with random in_valid/out_ready toggling → output equals original vector, order preserved.
